// File: rtl/conv_call_driver.sv
// ap_ctrl_hs call initiator for the complex convolver, with a double-buffered coefficient bank.
// Optional call watchdog is compiled in by defining CONV_TIMEOUT_EN.
module conv_call_driver #(
    parameter int NTAPS   = 32,
    parameter int W       = 18,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [W-1:0]               s_real,
    input  logic [W-1:0]               s_imag,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [W-1:0]               m_real,
    output logic [W-1:0]               m_imag,
    output logic                       conv_start,
    input  logic                       conv_ready,
    input  logic                       conv_done,
    output logic [W-1:0]               conv_x_real,
    output logic [W-1:0]               conv_x_imag,
    input  logic [W-1:0]               conv_res_real,
    input  logic                       conv_res_real_vld,
    input  logic [W-1:0]               conv_res_imag,
    input  logic                       conv_res_imag_vld,
    output logic [NTAPS-1:0][W-1:0]    coef_real,
    output logic [NTAPS-1:0][W-1:0]    coef_imag,
    input  logic                       coef_wr_en,
    input  logic [$clog2(NTAPS)-1:0]   coef_wr_addr,
    input  logic [W-1:0]               coef_wr_real,
    input  logic [W-1:0]               coef_wr_imag,
    input  logic                       coef_commit,
    output logic                       commit_pending,
    output logic                       missing_vld,
    output logic [31:0]                call_count,
    output logic                       timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_OUT       = 2'd3
    } state_t;

    typedef logic [NTAPS-1:0][W-1:0] bank_t;

    state_t      state_q, state_d;
    logic        s_ready_q, s_ready_d;
    logic        m_valid_q, m_valid_d;
    logic [W-1:0] m_real_q, m_real_d;
    logic [W-1:0] m_imag_q, m_imag_d;
    logic        conv_start_q, conv_start_d;
    logic [W-1:0] x_real_q, x_real_d;
    logic [W-1:0] x_imag_q, x_imag_d;
    logic        real_seen_q, real_seen_d;
    logic        imag_seen_q, imag_seen_d;
    logic        commit_pending_q, commit_pending_d;
    logic        missing_vld_q, missing_vld_d;
    logic [31:0] call_count_q, call_count_d;
    bank_t       shadow_real_q, shadow_real_d;
    bank_t       shadow_imag_q, shadow_imag_d;
    bank_t       active_real_q, active_real_d;
    bank_t       active_imag_q, active_imag_d;
    logic        accept_s;
    logic        apply_s;
    logic        busy_s;
    logic        timeout_hit_s;

    assign busy_s = (state_q == ST_START) || (state_q == ST_WAIT_DONE);

`ifdef CONV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_q, wd_d;
    logic          timeout_err_q, timeout_err_d;

    assign timeout_hit_s = busy_s && (wd_q == TW'(TIMEOUT - 1));

    // Watchdog counter and sticky error; a timeout is a limit hit that really sends the FSM home.
    always_comb begin
        wd_d          = '0;
        timeout_err_d = timeout_err_q;
        if (busy_s) begin
            wd_d = wd_q + TW'(1);
        end else begin
            wd_d = '0;
        end
        if (timeout_hit_s && (state_d == ST_IDLE)) begin
            timeout_err_d = 1'b1;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // Call sequencing, result capture and coefficient bank management.
    always_comb begin
        state_d          = state_q;
        m_real_d         = m_real_q;
        m_imag_d         = m_imag_q;
        x_real_d         = x_real_q;
        x_imag_d         = x_imag_q;
        real_seen_d      = real_seen_q;
        imag_seen_d      = imag_seen_q;
        missing_vld_d    = missing_vld_q;
        call_count_d     = call_count_q;
        shadow_real_d    = shadow_real_q;
        shadow_imag_d    = shadow_imag_q;
        active_real_d    = active_real_q;
        active_imag_d    = active_imag_q;
        commit_pending_d = commit_pending_q;
        s_ready_d        = 1'b0;
        m_valid_d        = 1'b0;
        conv_start_d     = 1'b0;

        accept_s = (state_q == ST_IDLE) && s_ready_q && s_valid;
        apply_s  = (state_q == ST_IDLE) && commit_pending_q;

        if (coef_wr_en) begin
            shadow_real_d[coef_wr_addr] = coef_wr_real;
            shadow_imag_d[coef_wr_addr] = coef_wr_imag;
        end else begin
            shadow_real_d = shadow_real_q;
            shadow_imag_d = shadow_imag_q;
        end

        // Copying shadow_*_d folds a same-cycle write into the commit.
        if (apply_s) begin
            active_real_d = shadow_real_d;
            active_imag_d = shadow_imag_d;
        end else begin
            active_real_d = active_real_q;
            active_imag_d = active_imag_q;
        end
        commit_pending_d = (commit_pending_q || coef_commit) && !apply_s;

        if (busy_s && conv_res_real_vld) begin
            m_real_d    = conv_res_real;
            real_seen_d = 1'b1;
        end else begin
            m_real_d    = m_real_q;
            real_seen_d = real_seen_q;
        end
        if (busy_s && conv_res_imag_vld) begin
            m_imag_d    = conv_res_imag;
            imag_seen_d = 1'b1;
        end else begin
            m_imag_d    = m_imag_q;
            imag_seen_d = imag_seen_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    x_real_d    = s_real;
                    x_imag_d    = s_imag;
                    real_seen_d = 1'b0;
                    imag_seen_d = 1'b0;
                    state_d     = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (conv_ready && conv_done) begin
                    state_d = ST_OUT;
                end else if (timeout_hit_s) begin
                    state_d = ST_IDLE;
                end else if (conv_ready) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_WAIT_DONE: begin
                if (conv_done) begin
                    state_d = ST_OUT;
                end else if (timeout_hit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    state_d      = ST_IDLE;
                    call_count_d = call_count_q + 32'd1;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_OUT) && (state_q != ST_OUT) && !(real_seen_d && imag_seen_d)) begin
            missing_vld_d = 1'b1;
        end else begin
            missing_vld_d = missing_vld_q;
        end

        conv_start_d = (state_d == ST_START);
        m_valid_d    = (state_d == ST_OUT);
        s_ready_d    = (state_d == ST_IDLE) && !commit_pending_d;
    end

    // Main state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            s_ready_q        <= 1'b0;
            m_valid_q        <= 1'b0;
            m_real_q         <= '0;
            m_imag_q         <= '0;
            conv_start_q     <= 1'b0;
            x_real_q         <= '0;
            x_imag_q         <= '0;
            real_seen_q      <= 1'b0;
            imag_seen_q      <= 1'b0;
            commit_pending_q <= 1'b0;
            missing_vld_q    <= 1'b0;
            call_count_q     <= 32'd0;
            shadow_real_q    <= '0;
            shadow_imag_q    <= '0;
            active_real_q    <= '0;
            active_imag_q    <= '0;
        end else begin
            state_q          <= state_d;
            s_ready_q        <= s_ready_d;
            m_valid_q        <= m_valid_d;
            m_real_q         <= m_real_d;
            m_imag_q         <= m_imag_d;
            conv_start_q     <= conv_start_d;
            x_real_q         <= x_real_d;
            x_imag_q         <= x_imag_d;
            real_seen_q      <= real_seen_d;
            imag_seen_q      <= imag_seen_d;
            commit_pending_q <= commit_pending_d;
            missing_vld_q    <= missing_vld_d;
            call_count_q     <= call_count_d;
            shadow_real_q    <= shadow_real_d;
            shadow_imag_q    <= shadow_imag_d;
            active_real_q    <= active_real_d;
            active_imag_q    <= active_imag_d;
        end
    end

    assign s_ready        = s_ready_q;
    assign m_valid        = m_valid_q;
    assign m_real         = m_real_q;
    assign m_imag         = m_imag_q;
    assign conv_start     = conv_start_q;
    assign conv_x_real    = x_real_q;
    assign conv_x_imag    = x_imag_q;
    assign coef_real      = active_real_q;
    assign coef_imag      = active_imag_q;
    assign commit_pending = commit_pending_q;
    assign missing_vld    = missing_vld_q;
    assign call_count     = call_count_q;

endmodule

// File: tb/tb_conv_call_driver.sv
// Self-checking bench for conv_call_driver: the bench plays the convolver and keeps its own
// coefficient-bank / result model. Define CONV_TIMEOUT_EN to also exercise the watchdog.
module tb_conv_call_driver;

    localparam int NTAPS = 32;
    localparam int W     = 18;
    localparam int AW    = $clog2(NTAPS);
    localparam int TO    = 16;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    s_valid, s_ready;
    logic [W-1:0]            s_real, s_imag;
    logic                    m_valid, m_ready;
    logic [W-1:0]            m_real, m_imag;
    logic                    conv_start, conv_ready, conv_done;
    logic [W-1:0]            conv_x_real, conv_x_imag;
    logic [W-1:0]            conv_res_real, conv_res_imag;
    logic                    conv_res_real_vld, conv_res_imag_vld;
    logic [NTAPS-1:0][W-1:0] coef_real, coef_imag;
    logic                    coef_wr_en;
    logic [AW-1:0]           coef_wr_addr;
    logic [W-1:0]            coef_wr_real, coef_wr_imag;
    logic                    coef_commit, commit_pending, missing_vld, timeout_err;
    logic [31:0]             call_count;

    always #5 clk = ~clk;

    conv_call_driver #(.NTAPS(NTAPS), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
        .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
        .conv_start(conv_start), .conv_ready(conv_ready), .conv_done(conv_done),
        .conv_x_real(conv_x_real), .conv_x_imag(conv_x_imag),
        .conv_res_real(conv_res_real), .conv_res_real_vld(conv_res_real_vld),
        .conv_res_imag(conv_res_imag), .conv_res_imag_vld(conv_res_imag_vld),
        .coef_real(coef_real), .coef_imag(coef_imag),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr),
        .coef_wr_real(coef_wr_real), .coef_wr_imag(coef_wr_imag),
        .coef_commit(coef_commit), .commit_pending(commit_pending),
        .missing_vld(missing_vld), .call_count(call_count), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [W-1:0] xr, xi;
        int           rdy_cyc, done_cyc, stb_cyc;
        bit           re, ie;
        int           bp;
        bit           mid_wr;
        bit           use_exp;
        logic [W-1:0] exp_r, exp_i;
        bit           exp_miss;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: banks as arrays, result = sum over taps of coef * x_real.
    logic [W-1:0] sh_r[NTAPS], sh_i[NTAPS], ac_r[NTAPS], ac_i[NTAPS];
    bit           pend_m, miss_m;
    int unsigned  cnt_m;
    logic [W-1:0] last_r, last_i;

    task automatic chk(input string nm, input logic [NTAPS*W-1:0] act, input logic [NTAPS*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] sv(input int x);
        return x[W-1:0];
    endfunction

    function automatic logic [NTAPS*W-1:0] pack(input bit imag);
        logic [NTAPS-1:0][W-1:0] p;
        for (int k = 0; k < NTAPS; k++) p[k] = imag ? ac_i[k] : ac_r[k];
        return p;
    endfunction

    function automatic logic [W-1:0] dot(input bit imag, input logic [W-1:0] x);
        longint s = 0;
        for (int k = 0; k < NTAPS; k++)
            s += longint'($signed(imag ? ac_i[k] : ac_r[k])) * longint'($signed(x));
        return s[W-1:0];
    endfunction

    // Convolver stand-in: computes its answer from what the DUT actually presents.
    function automatic logic [W-1:0] resp(input bit imag);
        longint s = 0;
        for (int k = 0; k < NTAPS; k++)
            s += longint'($signed(imag ? coef_imag[k] : coef_real[k])) * longint'($signed(conv_x_real));
        return s[W-1:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NTAPS; k++) begin
            sh_r[k] = '0; sh_i[k] = '0; ac_r[k] = '0; ac_i[k] = '0;
        end
        pend_m = 1'b0; miss_m = 1'b0; cnt_m = 0; last_r = '0; last_i = '0;
    endtask

    task automatic apply_model();
        for (int k = 0; k < NTAPS; k++) begin
            ac_r[k] = sh_r[k]; ac_i[k] = sh_i[k];
        end
        pend_m = 1'b0;
    endtask

    task automatic wr(input int addr, input logic [W-1:0] r, input logic [W-1:0] i, input bit commit);
        coef_wr_en = 1'b1; coef_wr_addr = AW'(addr); coef_wr_real = r; coef_wr_imag = i;
        coef_commit = commit;
        sh_r[addr] = r; sh_i[addr] = i;
        if (commit) pend_m = 1'b1;
        tick();
        coef_wr_en = 1'b0; coef_commit = 1'b0;
    endtask

    // Called in IDLE right after a commit: repeats it while pending, then expects one apply.
    task automatic commit_apply();
        chk("commit_pending_set", commit_pending, 1'b1);
        chk("s_ready_during_commit", s_ready, 1'b0);
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        apply_model();
        chk("commit_pending_clear", commit_pending, 1'b0);
        chk("s_ready_after_commit", s_ready, 1'b1);
        chk("bank_real", coef_real, pack(1'b0));
        chk("bank_imag", coef_imag, pack(1'b1));
    endtask

    task automatic load_taps(input int n);
        for (int j = 0; j < n; j++)
            wr(int'($urandom_range(0, NTAPS - 1)), sv(int'($urandom_range(0, 1023)) - 512),
               sv(int'($urandom_range(0, 1023)) - 512), j == n - 1);
        commit_apply();
    endtask

    task automatic send_sample(input logic [W-1:0] xr, input logic [W-1:0] xi);
        int n = 0;
        s_valid = 1'b1; s_real = xr; s_imag = xi;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL accept_wait: got s_ready=0 expected 1 within 50 cycles");
        end
        tick();
        s_valid = 1'b0; s_real = W'($urandom); s_imag = W'($urandom);
    endtask

    task automatic run_call(input vec_t v);
        int starts = 0;
        logic [W-1:0] er, ei, hr, hi;
        send_sample(v.xr, v.xi);
        chk("x_real_after_accept", conv_x_real, v.xr);
        chk("x_imag_after_accept", conv_x_imag, v.xi);
        chk("s_ready_busy", s_ready, 1'b0);
        for (int c = 1; c <= v.done_cyc; c++) begin
            if (conv_start) starts++;
            if (v.mid_wr && c == v.rdy_cyc + 1) begin
                coef_wr_en = 1'b1; coef_wr_addr = '0; coef_wr_real = sv(55); coef_wr_imag = sv(-3);
                coef_commit = 1'b1; sh_r[0] = sv(55); sh_i[0] = sv(-3); pend_m = 1'b1;
            end
            if (c == v.done_cyc) begin
                chk("coef_stable_real", coef_real, pack(1'b0));
                chk("x_stable", conv_x_real, v.xr);
            end
            conv_ready = (c == v.rdy_cyc);
            conv_done  = (c == v.done_cyc);
            conv_res_real_vld = v.re && (c == v.stb_cyc);
            conv_res_imag_vld = v.ie && (c == v.stb_cyc);
            conv_res_real = conv_res_real_vld ? resp(1'b0) : W'($urandom);
            conv_res_imag = conv_res_imag_vld ? resp(1'b1) : W'($urandom);
            tick();
            coef_wr_en = 1'b0; coef_commit = 1'b0;
        end
        conv_ready = 1'b0; conv_done = 1'b0; conv_res_real_vld = 1'b0; conv_res_imag_vld = 1'b0;
        er = v.re ? dot(1'b0, v.xr) : last_r;
        ei = v.ie ? dot(1'b1, v.xr) : last_i;
        last_r = er; last_i = ei;
        if (!(v.re && v.ie)) miss_m = 1'b1;
        chk("start_cycles", starts, v.rdy_cyc);
        chk("start_dropped", conv_start, 1'b0);
        chk("m_valid_after_done", m_valid, 1'b1);
        chk("m_real", m_real, er);
        chk("m_imag", m_imag, ei);
        chk("missing_vld", missing_vld, miss_m);
        if (v.use_exp) begin
            chk("m_real_table", m_real, v.exp_r);
            chk("m_imag_table", m_imag, v.exp_i);
            chk("missing_table", missing_vld, v.exp_miss);
        end
        hr = m_real; hi = m_imag;
        m_ready = 1'b0;
        for (int b = 0; b < v.bp; b++) begin
            tick();
            chk("bp_valid", m_valid, 1'b1);
            chk("bp_data", {m_real, m_imag}, {hr, hi});
            chk("bp_s_ready", s_ready, 1'b0);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        cnt_m++;
        chk("m_valid_cleared", m_valid, 1'b0);
        chk("call_count", call_count, cnt_m);
        chk("s_ready_idle", s_ready, !pend_m);
        chk("pending_idle", commit_pending, pend_m);
        if (pend_m) begin
            chk("coef_old_in_apply_cycle", coef_real, pack(1'b0));
            tick();
            apply_model();
            chk("coef_real_applied", coef_real, pack(1'b0));
            chk("coef_imag_applied", coef_imag, pack(1'b1));
            chk("s_ready_after_apply", s_ready, 1'b1);
            chk("pending_after_apply", commit_pending, 1'b0);
        end
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_outs"}, {s_ready, m_valid, conv_start, commit_pending, missing_vld, timeout_err}, '0);
        chk({nm, "_data"}, {m_real, m_imag, conv_x_real, conv_x_imag, call_count}, '0);
        chk({nm, "_coef_r"}, coef_real, '0);
        chk({nm, "_coef_i"}, coef_imag, '0);
    endtask

    vec_t tbl[5];
    vec_t rv;

    initial begin
        tbl[0] = '{sv(7),  sv(2),  3, 13, 13, 1'b1, 1'b1, 0,  1'b0, 1'b1, sv(700),  sv(-35), 1'b0};
        tbl[1] = '{sv(3),  sv(-1), 1, 6,  4,  1'b1, 1'b1, 2,  1'b1, 1'b1, sv(300),  sv(-15), 1'b0};
        tbl[2] = '{sv(4),  sv(9),  2, 2,  2,  1'b1, 1'b1, 0,  1'b0, 1'b1, sv(620),  sv(-32), 1'b0};
        tbl[3] = '{sv(2),  sv(0),  1, 4,  3,  1'b1, 1'b0, 0,  1'b0, 1'b1, sv(310),  sv(-32), 1'b1};
        tbl[4] = '{sv(-1), sv(5),  2, 5,  1,  1'b1, 1'b1, 20, 1'b0, 1'b1, sv(-155), sv(8),   1'b1};

        reset = 1'b1; s_valid = 1'b0; s_real = '0; s_imag = '0; m_ready = 1'b0;
        conv_ready = 1'b0; conv_done = 1'b0; conv_res_real = '0; conv_res_imag = '0;
        conv_res_real_vld = 1'b0; conv_res_imag_vld = 1'b0;
        coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_real = '0; coef_wr_imag = '0; coef_commit = 1'b0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        chk_reset_state("reset");
        tick();
        chk("s_ready_after_reset", s_ready, 1'b1);

        wr(3, sv(100), sv(-5), 1'b1);
        commit_apply();
        for (int t = 0; t < 5; t++) run_call(tbl[t]);

        // Stray done and strobes in IDLE must not disturb anything.
        conv_done = 1'b1; conv_res_real_vld = 1'b1; conv_res_real = sv(1234);
        tick();
        conv_done = 1'b0; conv_res_real_vld = 1'b0;
        chk("stray_done_m_valid", m_valid, 1'b0);
        chk("stray_strobe_m_real", m_real, last_r);
        chk("stray_done_s_ready", s_ready, 1'b1);

        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 2) == 0) load_taps(int'($urandom_range(1, 4)));
            rv.xr = sv(int'($urandom_range(0, 255)) - 128);
            rv.xi = W'($urandom);
            rv.rdy_cyc  = int'($urandom_range(1, 4));
            rv.done_cyc = rv.rdy_cyc + int'($urandom_range(0, 5));
            rv.stb_cyc  = int'($urandom_range(1, rv.done_cyc));
            rv.re = ($urandom_range(0, 4) != 0);
            rv.ie = ($urandom_range(0, 4) != 0);
            rv.bp = int'($urandom_range(0, 3));
            rv.mid_wr = 1'b0; rv.use_exp = 1'b0;
            rv.exp_r = '0; rv.exp_i = '0; rv.exp_miss = 1'b0;
            run_call(rv);
        end

`ifdef CONV_TIMEOUT_EN
        send_sample(sv(1), sv(1));
        for (int c = 1; c <= TO; c++) begin
            chk("timeout_not_yet", timeout_err, 1'b0);
            tick();
        end
        chk("timeout_err_set", timeout_err, 1'b1);
        chk("timeout_start_dropped", conv_start, 1'b0);
        chk("timeout_no_output", m_valid, 1'b0);
        chk("timeout_count", call_count, cnt_m);
        chk("timeout_back_idle", s_ready, 1'b1);
`else
        chk("timeout_tied_low", timeout_err, 1'b0);
`endif

        // Reset while the call is still waiting for conv_ready.
        send_sample(sv(9), sv(9));
        tick();
        chk("start_before_reset", conv_start, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        chk_reset_state("midreset");
        tick();
        chk("s_ready_after_midreset", s_ready, 1'b1);
        rv = tbl[0];
        rv.use_exp = 1'b0;
        run_call(rv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
